// File: rtl/raycast_node_fetch_pkg.sv
// Shared definitions for the SVO node fetch unit: descriptor field
// positions, FSM state encoding and a child-slot address helper.
package raycast_node_fetch_pkg;

    localparam int CHILD_PTR_MSB = 31;
    localparam int CHILD_PTR_LSB = 17;
    localparam int FAR_BIT       = 16;
    localparam int VALID_MSB     = 15;
    localparam int VALID_LSB     = 8;
    localparam int LEAF_MSB      = 7;
    localparam int LEAF_LSB      = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_PARENT = 3'd1,
        ST_CALC      = 3'd2,
        ST_RD_FAR    = 3'd3,
        ST_RD_CHILD  = 3'd4,
        ST_RESP      = 3'd5
    } fetch_state_t;

    // Byte address of the off-th occupied slot after a child block base.
    function automatic logic [31:0] slot_adr(input logic [31:0] base,
                                             input logic [2:0]  off);
        return base + {27'd0, off, 2'b00};
    endfunction

endpackage

// File: rtl/raycast_popcnt8.sv
// Counts the set bits of an 8-bit mask strictly below a given index.
// Shared with the traversal core for child-slot offset computation.
module raycast_popcnt8 (
    input  logic [7:0] bits,
    input  logic [2:0] idx,
    output logic [2:0] cnt
);

    // Sum of bits[i] for i < idx; at most 7, so 3 bits suffice.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(idx)) begin
                cnt = cnt + {2'b00, bits[i]};
            end
        end
    end

endmodule

// File: rtl/raycast_node_fetch.sv
// One-level SVO walk: read the parent descriptor, optionally resolve a far
// pointer against the tree root, then read the child descriptor.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   IDLE        | ready for a request
//   RD_PARENT   | single-beat read of the parent descriptor
//   CALC        | decode parent, pick empty / leaf / far / near path
//   RD_FAR      | read far pointer word at node + child_ptr*4
//   RD_CHILD    | read child descriptor (issued after a one-cycle gap)
//   RESP        | result presented until consumed
module raycast_node_fetch
    import raycast_node_fetch_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [AW-1:0] root_adr_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [AW-1:0] req_node_adr_i,
    input  logic [2:0]    req_child_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [AW-1:0] rsp_desc_o,
    output logic [AW-1:0] rsp_adr_o,
    output logic          rsp_empty_o,
    output logic          rsp_leaf_o,
    output logic [AW-1:0] wb_adr_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    input  logic [AW-1:0] wb_dat_i,
    input  logic          wb_ack_i
);

    fetch_state_t  state;
    logic [AW-1:0] node_adr_q;
    logic [2:0]    child_q;
    logic [AW-1:0] parent_q;
    logic [AW-1:0] child_adr_q;
    logic          wb_cyc_q;

    logic [7:0]    valid_mask;
    logic [7:0]    leaf_mask;
    logic [AW-1:0] ptr_bytes;
    logic [AW-1:0] near_base;
    logic [AW-1:0] near_adr;
    logic [AW-1:0] far_adr;
    logic [2:0]    slot_off;
    logic          child_present;
    logic          child_leaf;

    assign valid_mask    = parent_q[VALID_MSB:VALID_LSB];
    assign leaf_mask     = parent_q[LEAF_MSB:LEAF_LSB];
    assign ptr_bytes     = {{(AW-17){1'b0}}, parent_q[CHILD_PTR_MSB:CHILD_PTR_LSB], 2'b00};
    assign near_base     = node_adr_q + ptr_bytes;
    assign near_adr      = slot_adr(near_base, slot_off);
    assign far_adr       = slot_adr(root_adr_i + wb_dat_i, slot_off);
    assign child_present = valid_mask[child_q];
    assign child_leaf    = leaf_mask[child_q];

    assign wb_cyc_o = wb_cyc_q;
    assign wb_stb_o = wb_cyc_q;

    raycast_popcnt8 u_popcnt (
        .bits (valid_mask),
        .idx  (child_q),
        .cnt  (slot_off)
    );

    // Fetch sequencer; every bus and response output is a flop of this block.
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state       <= ST_IDLE;
            req_ready_o <= 1'b1;
            node_adr_q  <= '0;
            child_q     <= '0;
            parent_q    <= '0;
            child_adr_q <= '0;
            wb_cyc_q    <= 1'b0;
            wb_adr_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_desc_o  <= '0;
            rsp_adr_o   <= '0;
            rsp_empty_o <= 1'b0;
            rsp_leaf_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        node_adr_q  <= req_node_adr_i;
                        child_q     <= req_child_i;
                        wb_cyc_q    <= 1'b1;
                        wb_adr_o    <= req_node_adr_i;
                        req_ready_o <= 1'b0;
                        state       <= ST_RD_PARENT;
                    end
                end
                ST_RD_PARENT: begin
                    if (wb_ack_i) begin
                        parent_q <= wb_dat_i;
                        wb_cyc_q <= 1'b0;
                        state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (!child_present) begin
                        rsp_empty_o <= 1'b1;
                        rsp_leaf_o  <= 1'b0;
                        rsp_adr_o   <= '0;
                        rsp_desc_o  <= '0;
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESP;
                    end else if (parent_q[FAR_BIT]) begin
                        wb_cyc_q <= 1'b1;
                        wb_adr_o <= near_base;
                        state    <= ST_RD_FAR;
                    end else if (child_leaf) begin
                        rsp_empty_o <= 1'b0;
                        rsp_leaf_o  <= 1'b1;
                        rsp_adr_o   <= near_adr;
                        rsp_desc_o  <= '0;
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        child_adr_q <= near_adr;
                        wb_cyc_q    <= 1'b1;
                        wb_adr_o    <= near_adr;
                        state       <= ST_RD_CHILD;
                    end
                end
                ST_RD_FAR: begin
                    if (wb_ack_i) begin
                        wb_cyc_q <= 1'b0;
                        if (child_leaf) begin
                            rsp_empty_o <= 1'b0;
                            rsp_leaf_o  <= 1'b1;
                            rsp_adr_o   <= far_adr;
                            rsp_desc_o  <= '0;
                            rsp_valid_o <= 1'b1;
                            state       <= ST_RESP;
                        end else begin
                            // Child read is issued from RD_CHILD next cycle,
                            // leaving cyc low for one cycle after this ack.
                            child_adr_q <= far_adr;
                            state       <= ST_RD_CHILD;
                        end
                    end
                end
                ST_RD_CHILD: begin
                    if (!wb_cyc_q) begin
                        wb_cyc_q <= 1'b1;
                        wb_adr_o <= child_adr_q;
                    end else if (wb_ack_i) begin
                        wb_cyc_q    <= 1'b0;
                        rsp_empty_o <= 1'b0;
                        rsp_leaf_o  <= 1'b0;
                        rsp_adr_o   <= child_adr_q;
                        rsp_desc_o  <= wb_dat_i;
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    wb_cyc_q    <= 1'b0;
                    rsp_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_raycast_node_fetch.sv
// Randomized scoreboard bench for raycast_node_fetch with a behavioural
// octree-walk reference model and a latency-randomized Wishbone memory.
module tb_raycast_node_fetch;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic [31:0] root_adr_i = '0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_node_adr_i = '0;
    logic [2:0]  req_child_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_desc_o;
    logic [31:0] rsp_adr_o;
    logic        rsp_empty_o;
    logic        rsp_leaf_o;
    logic [31:0] wb_adr_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;

    raycast_node_fetch #(.AW(32)) dut (
        .wb_clk         (wb_clk),
        .wb_rst         (wb_rst),
        .root_adr_i     (root_adr_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_node_adr_i (req_node_adr_i),
        .req_child_i    (req_child_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_desc_o     (rsp_desc_o),
        .rsp_adr_o      (rsp_adr_o),
        .rsp_empty_o    (rsp_empty_o),
        .rsp_leaf_o     (rsp_leaf_o),
        .wb_adr_o       (wb_adr_o),
        .wb_cyc_o       (wb_cyc_o),
        .wb_stb_o       (wb_stb_o),
        .wb_dat_i       (wb_dat_i),
        .wb_ack_i       (wb_ack_i)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct {
        logic [31:0]       desc;
        logic [31:0]       adr;
        logic              empty;
        logic              leaf;
        int                nrd;
        logic [2:0][31:0]  rd;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mem [logic [31:0]];
    exp_t        exp_q[$];
    logic [31:0] rd_log[$];
    int lat = 0, lat_min = 0, lat_max = 3;
    int hold_cnt = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    // Reference walk: plain arithmetic over the descriptor fields.
    function automatic exp_t model(input logic [31:0] root, input logic [31:0] node, input logic [2:0] ch);
        exp_t e;
        logic [31:0] p, base;
        logic [7:0]  vm, lm, below;
        int off;
        e.desc = '0; e.adr = '0; e.empty = 1'b0; e.leaf = 1'b0; e.rd = '0;
        p = mem_rd(node);
        e.nrd = 1;
        e.rd[0] = node;
        vm = p[15:8];
        lm = p[7:0];
        if (!vm[ch]) begin
            e.empty = 1'b1;
            return e;
        end
        below = 8'((9'd1 << ch) - 9'd1);
        off = $countones(vm & below);
        base = node + 32'(p[31:17]) * 32'd4;
        if (p[16]) begin
            e.rd[1] = base;
            e.nrd = 2;
            base = root + mem_rd(base);
        end
        e.adr = base + 32'(off * 4);
        if (lm[ch]) begin
            e.leaf = 1'b1;
            return e;
        end
        e.rd[e.nrd] = e.adr;
        e.nrd++;
        e.desc = mem_rd(e.adr);
        return e;
    endfunction

    // Wishbone memory: random ack latency, logs read addresses, checks bus rules.
    initial begin
        logic        prev_cyc;
        logic [31:0] prev_adr;
        prev_cyc = 1'b0;
        prev_adr = '0;
        forever begin
            @(negedge wb_clk);
            if (!wb_rst) begin
                wb_ack_i = 1'b0;
                prev_cyc = 1'b0;
                continue;
            end
            if (wb_ack_i) begin
                check32("cyc_low_after_ack", {31'd0, wb_cyc_o}, 32'd0);
                check32("stb_eq_cyc", {31'd0, wb_stb_o}, {31'd0, wb_cyc_o});
                wb_ack_i = 1'b0;
            end else if (wb_cyc_o) begin
                check32("stb_eq_cyc", {31'd0, wb_stb_o}, 32'd1);
                if (prev_cyc) check32("adr_stable", wb_adr_o, prev_adr);
                if (lat <= 0) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = mem_rd(wb_adr_o);
                    rd_log.push_back(wb_adr_o);
                    lat = $urandom_range(lat_max, lat_min);
                end else begin
                    lat--;
                end
            end
            prev_cyc = wb_cyc_o;
            prev_adr = wb_adr_o;
        end
    end

    // Response monitor: drives rsp_ready, checks hold/stability, pops scoreboard.
    initial begin
        logic        prev_v, prev_hs;
        logic [31:0] p_desc, p_adr;
        logic        p_empty, p_leaf;
        exp_t        e;
        prev_v = 1'b0; prev_hs = 1'b0;
        p_desc = '0; p_adr = '0; p_empty = 1'b0; p_leaf = 1'b0;
        forever begin
            @(negedge wb_clk);
            if (!wb_rst) begin
                rsp_ready_i = 1'b0;
                prev_v = 1'b0;
                prev_hs = 1'b0;
                continue;
            end
            if (prev_hs) begin
                check32("idle_after_rsp_hs", {31'd0, req_ready_o}, 32'd1);
                check32("valid_drop_after_hs", {31'd0, rsp_valid_o}, 32'd0);
            end else if (prev_v) begin
                check32("rsp_valid_held", {31'd0, rsp_valid_o}, 32'd1);
                check32("rsp_desc_stable", rsp_desc_o, p_desc);
                check32("rsp_adr_stable", rsp_adr_o, p_adr);
                check32("rsp_flags_stable", {30'd0, rsp_empty_o, rsp_leaf_o}, {30'd0, p_empty, p_leaf});
            end
            if (rsp_valid_o) check32("req_ready_busy", {31'd0, req_ready_o}, 32'd0);
            if (hold_cnt > 0) begin
                rsp_ready_i = 1'b0;
                if (rsp_valid_o) hold_cnt--;
            end else begin
                rsp_ready_i = ($urandom_range(3, 0) != 0);
            end
            if (rsp_valid_o && rsp_ready_i) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_response");
                end else begin
                    e = exp_q.pop_front();
                    check32("rsp_desc", rsp_desc_o, e.desc);
                    check32("rsp_adr", rsp_adr_o, e.adr);
                    check32("rsp_empty", {31'd0, rsp_empty_o}, {31'd0, e.empty});
                    check32("rsp_leaf", {31'd0, rsp_leaf_o}, {31'd0, e.leaf});
                    check32("read_count", rd_log.size(), e.nrd);
                    for (int k = 0; k < e.nrd; k++) begin
                        if (rd_log.size() > 0) check32("read_adr", rd_log.pop_front(), e.rd[k]);
                    end
                    rd_log.delete();
                end
            end
            prev_hs = rsp_valid_o && rsp_ready_i;
            prev_v  = rsp_valid_o;
            p_desc = rsp_desc_o; p_adr = rsp_adr_o; p_empty = rsp_empty_o; p_leaf = rsp_leaf_o;
        end
    end

    task automatic send(input logic [31:0] node, input logic [2:0] ch, input bit keep_valid);
        int t;
        t = 0;
        req_node_adr_i = node;
        req_child_i    = ch;
        req_valid_i    = 1'b1;
        while (!req_ready_o && t < 4000) begin
            @(negedge wb_clk);
            t++;
        end
        if (!req_ready_o) begin
            fail_now("req_accept");
            req_valid_i = 1'b0;
            return;
        end
        exp_q.push_back(model(root_adr_i, node, ch));
        @(negedge wb_clk);
        if (!keep_valid) req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !req_ready_o) && t < 4000) begin
            @(negedge wb_clk);
            t++;
        end
        if (t >= 4000) fail_now("wait_idle");
    endtask

    initial begin
        logic [31:0] node;
        logic [14:0] cp;
        logic        far;
        int t;

        #1 wb_rst = 1'b0;
        @(negedge wb_clk);
        @(negedge wb_clk);
        check32("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check32("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        check32("rst_wb_adr", wb_adr_o, 32'd0);
        check32("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check32("rst_rsp_desc", rsp_desc_o, 32'd0);
        check32("rst_rsp_adr", rsp_adr_o, 32'd0);
        check32("rst_rsp_flags", {30'd0, rsp_empty_o, rsp_leaf_o}, 32'd0);
        check32("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        wb_rst = 1'b1;
        @(negedge wb_clk);

        // Directed walks from the test plan.
        root_adr_i = 32'h0000_1000;
        mem[32'h1000] = 32'h0004_B600;
        mem[32'h1010] = 32'hDEAD_BEEF;
        send(32'h1000, 3'd4, 1'b0);
        wait_idle();
        send(32'h1000, 3'd0, 1'b0);
        wait_idle();
        mem[32'h1000] = 32'h0004_B610;
        send(32'h1000, 3'd4, 1'b0);
        wait_idle();
        mem[32'h1000] = 32'h0007_B600;
        mem[32'h100C] = 32'h0000_0200;
        send(32'h1000, 3'd4, 1'b0);
        wait_idle();

        // Backpressure with a second request already waiting.
        mem[32'h1000] = 32'h0004_B600;
        hold_cnt = 5;
        send(32'h1000, 3'd4, 1'b1);
        send(32'h1000, 3'd0, 1'b0);
        wait_idle();

        // Reset while the far pointer read is outstanding.
        mem[32'h1000] = 32'h0007_B600;
        lat_min = 6; lat_max = 8;
        send(32'h1000, 3'd4, 1'b0);
        t = 0;
        while (!(wb_cyc_o && wb_adr_o == 32'h100C) && t < 200) begin
            @(negedge wb_clk);
            t++;
        end
        if (t >= 200) fail_now("reach_rd_far");
        #2 wb_rst = 1'b0;
        #1;
        check32("arst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check32("arst_stb", {31'd0, wb_stb_o}, 32'd0);
        check32("arst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check32("arst_req_ready", {31'd0, req_ready_o}, 32'd1);
        exp_q.delete();
        rd_log.delete();
        lat = 0; lat_min = 0; lat_max = 3;
        @(negedge wb_clk);
        @(negedge wb_clk);
        wb_rst = 1'b1;
        @(negedge wb_clk);
        send(32'h1000, 3'd4, 1'b0);
        wait_idle();

        // Randomized walks, including far pointers and address wrap.
        for (int it = 0; it < 60; it++) begin
            wait_idle();
            root_adr_i = $urandom() & 32'hFFFF_FFFC;
            node = 32'h0000_4000 + {20'd0, 10'($urandom_range(1023, 0)), 2'b00};
            cp   = 15'($urandom_range(63, 0));
            far  = ($urandom_range(2, 0) == 0);
            mem[node] = {cp, far, 8'($urandom()), 8'($urandom())};
            if (far) mem[node + 32'(cp) * 32'd4] = $urandom() & 32'hFFFF_FFFC;
            send(node, 3'($urandom_range(7, 0)), 1'b0);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        fail_now("global_watchdog");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
